// File: rtl/counter_sequencer.sv
// counter_sequencer: accepts queued commands and drives the 8-bit step counter's
// control inputs cycle-exactly (preload, run N steps, hold N cycles, seek target).
module counter_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic                        cmd_dir,
    input  logic [7:0]                  cmd_data,
    input  logic [3:0]                  cmd_incr,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic                        abort,
    output logic                        cnt_enable,
    output logic                        cnt_updn,
    output logic                        cnt_preload,
    output logic [7:0]                  cnt_pl_data,
    output logic [3:0]                  cnt_incr,
    input  logic [7:0]                  cnt_cout,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  done_status,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_RUN  = 2'd1;
    localparam logic [1:0] OP_HOLD = 2'd2;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_HIT     = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORT   = 2'd3;

    typedef struct packed {
        logic [1:0]       op;
        logic             dir;
        logic [7:0]       data;
        logic [3:0]       incr;
        logic [LEN_W-1:0] len;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_HOLD, S_SEEK_EVAL, S_SEEK_RUN
    } state_t;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push, pop, empty;
    cmd_t             head, cmd_in;

    state_t           state, state_n;
    logic [LEN_W-1:0] rem, rem_n;
    logic             cur_dir;
    logic [7:0]       cur_data;
    logic [3:0]       cur_incr;
    logic [LEN_W-1:0] cur_len;
    logic [7:0]       predicted;
    logic             last;

    logic             enable_n, updn_n, preload_n, done_n;
    logic [7:0]       pl_data_n;
    logic [3:0]       incr_n;
    logic [1:0]       status_n;

    assign cmd_ready  = (count != LVL_W'(FIFO_DEPTH)) && !abort && !reset;
    assign push       = cmd_valid && cmd_ready;
    assign empty      = (count == '0);
    assign head       = fifo_mem[rd_ptr];
    assign cmd_in     = '{op: cmd_op, dir: cmd_dir, data: cmd_data, incr: cmd_incr, len: cmd_len};
    assign fifo_level = count;
    assign busy       = (state != S_IDLE) || !empty;
    assign predicted  = cur_dir ? (cnt_cout - {4'd0, cur_incr}) : (cnt_cout + {4'd0, cur_incr});

    // Command storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= cmd_in;
        end
    end

    // Queue pointers and occupancy; abort flushes the queue along with reset
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next state, next registered controls and completion reporting
    always_comb begin
        state_n   = state;
        rem_n     = rem;
        pop       = 1'b0;
        last      = 1'b0;
        enable_n  = 1'b0;
        updn_n    = 1'b0;
        preload_n = 1'b0;
        pl_data_n = 8'd0;
        incr_n    = 4'd0;
        done_n    = 1'b0;
        status_n  = ST_OK;

        unique case (state)
            S_IDLE: begin
                last = 1'b1;
            end
            S_LOAD: begin
                last   = 1'b1;
                done_n = 1'b1;
            end
            S_RUN, S_HOLD: begin
                if (rem <= LEN_W'(1)) begin
                    last   = 1'b1;
                    done_n = 1'b1;
                end else begin
                    rem_n = rem - LEN_W'(1);
                    if (state == S_RUN) begin
                        enable_n = 1'b1;
                        updn_n   = cur_dir;
                        incr_n   = cur_incr;
                    end
                end
            end
            S_SEEK_EVAL: begin
                if (cnt_cout == cur_data) begin
                    last     = 1'b1;
                    done_n   = 1'b1;
                    status_n = ST_HIT;
                end else if (cur_len == '0) begin
                    last     = 1'b1;
                    done_n   = 1'b1;
                    status_n = ST_TIMEOUT;
                end else begin
                    state_n  = S_SEEK_RUN;
                    rem_n    = cur_len;
                    enable_n = 1'b1;
                    updn_n   = cur_dir;
                    incr_n   = cur_incr;
                end
            end
            S_SEEK_RUN: begin
                if (predicted == cur_data) begin
                    last     = 1'b1;
                    done_n   = 1'b1;
                    status_n = ST_HIT;
                end else if (rem == LEN_W'(1)) begin
                    last     = 1'b1;
                    done_n   = 1'b1;
                    status_n = ST_TIMEOUT;
                end else begin
                    rem_n    = rem - LEN_W'(1);
                    enable_n = 1'b1;
                    updn_n   = cur_dir;
                    incr_n   = cur_incr;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (last) begin
            if (!empty) begin
                pop   = 1'b1;
                rem_n = head.len;
                case (head.op)
                    OP_LOAD: begin
                        state_n   = S_LOAD;
                        preload_n = 1'b1;
                        pl_data_n = head.data;
                    end
                    OP_RUN: begin
                        state_n = S_RUN;
                        if (head.len != '0) begin
                            enable_n = 1'b1;
                            updn_n   = head.dir;
                            incr_n   = head.incr;
                        end
                    end
                    OP_HOLD: begin
                        state_n = S_HOLD;
                    end
                    default: begin
                        state_n = S_SEEK_EVAL;
                    end
                endcase
            end else begin
                state_n = S_IDLE;
            end
        end

        if (abort) begin
            state_n   = S_IDLE;
            pop       = 1'b0;
            enable_n  = 1'b0;
            updn_n    = 1'b0;
            preload_n = 1'b0;
            pl_data_n = 8'd0;
            incr_n    = 4'd0;
            done_n    = (state != S_IDLE);
            status_n  = ST_ABORT;
        end
    end

    // State, remaining-cycle count, active command fields and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            rem         <= '0;
            cur_dir     <= 1'b0;
            cur_data    <= 8'd0;
            cur_incr    <= 4'd0;
            cur_len     <= '0;
            cnt_enable  <= 1'b0;
            cnt_updn    <= 1'b0;
            cnt_preload <= 1'b0;
            cnt_pl_data <= 8'd0;
            cnt_incr    <= 4'd0;
            done        <= 1'b0;
            done_status <= 2'd0;
        end else begin
            state       <= state_n;
            rem         <= rem_n;
            if (pop) begin
                cur_dir  <= head.dir;
                cur_data <= head.data;
                cur_incr <= head.incr;
                cur_len  <= head.len;
            end
            cnt_enable  <= enable_n;
            cnt_updn    <= updn_n;
            cnt_preload <= preload_n;
            cnt_pl_data <= pl_data_n;
            cnt_incr    <= incr_n;
            done        <= done_n;
            done_status <= done_n ? status_n : 2'd0;
        end
    end

endmodule
